char_blender_pipe: RTL and testbench
====================================

CHAR_BLENDER_PIPE -- requirements
Module: char_blender_pipe

Interface
REQ-001 SHALL have parameter CHAR_W, default 8, meaning glyph cell width in pixels (power of 2, 8 or 16).
REQ-002 SHALL have parameter CHAR_H, default 8, meaning glyph cell height in pixels (power of 2, 8 or 16).
REQ-003 SHALL have parameter ALPHA_BITS, default 3, meaning per-pixel glyph alpha width; AMAX = 2^ALPHA_BITS-1.
REQ-004 SHALL have parameter BLINK_FRAMES, default 32, meaning frames per blink half-period (>=2).
REQ-005 SHALL have parameter GLYPH_FILE, default "glyphs.mem", meaning the ROM init file.
REQ-006 SHALL have port i_clk, input, 1, the single clock.
REQ-007 SHALL have port i_rst_n, input, 1, synchronous active-low reset.
REQ-008 SHALL have port i_frame_start, input, 1, one-cycle pulse per video frame.
REQ-009 SHALL have port i_valid, input, 1, pixel request valid.
REQ-010 SHALL have port o_ready, output, 1, request accepted when i_valid&&o_ready.
REQ-011 SHALL have ports i_char (8), i_row (clog2 CHAR_H), i_column (clog2 CHAR_W), i_fg_color (12) and i_bg_color (12), all inputs.
REQ-012 SHALL have port i_attr, input, 3: bit0 inverse, bit1 underline, bit2 blink.
REQ-013 SHALL have ports o_valid (output, 1), i_ready (input, 1) and o_color (output, 12, RGB 4:4:4).

Function
REQ-014 SHALL be a 3-stage pipeline: S1 registers the request and glyph address; S2 performs the synchronous ROM read; S3 applies attributes, blends and registers o_color.
REQ-015 SHALL present the result for an accepted request on o_valid/o_color exactly 3 cycles after acceptance when not stalled.
REQ-016 SHALL compute adv = !v3 || i_ready, drive o_ready = adv, and advance all stages only when adv=1; it SHALL hold all stage registers while adv=0.
REQ-017 SHALL load a bubble (valid 0) into S1 when adv=1 and i_valid=0.
REQ-018 SHALL address the glyph ROM as {i_char, i_row, i_column}, a 256*CHAR_H*CHAR_W x ALPHA_BITS array.
REQ-019 SHALL swap fg and bg before blending when inverse=1.
REQ-020 SHALL force alpha=AMAX when underline=1 and row==CHAR_H-1.
REQ-021 SHALL force alpha=0 when blink=1 and the request's captured blink phase is 1; underline SHALL also be suppressed in that case.
REQ-022 SHALL compute, per 4-bit channel, out = (fg*a + bg*(AMAX-a) + AMAX/2) / AMAX using integer arithmetic at least 4+ALPHA_BITS+1 bits wide, so a=0 gives bg exactly and a=AMAX gives fg exactly.
REQ-023 SHALL count i_frame_start pulses in a 0..BLINK_FRAMES-1 counter; on the pulse at count BLINK_FRAMES-1 it SHALL wrap to 0 and toggle blink_phase.
REQ-024 SHALL run the blink counter regardless of the stall state; each request's phase SHALL be the value sampled at S1 acceptance.
REQ-025 SHALL hold o_color at its last value when o_valid=0.

Reset
REQ-026 SHALL, while i_rst_n=0 at an i_clk edge, clear all stage valids, o_color, the blink counter and blink_phase to 0; o_ready SHALL then read 1.
REQ-027 SHALL discard in-flight requests on reset mid-operation; no o_valid SHALL occur in the cycle after reset deasserts.
REQ-028 SHALL not reset ROM contents.

Structure
REQ-029 SHALL place the attribute bit indices and the RGB 4:4:4 channel field positions in shared package video_pkg.
REQ-030 SHALL instantiate the ROM as sub-module char_glyph_rom (parameters CHAR_W, CHAR_H, ALPHA_BITS, GLYPH_FILE; registered read with enable).

Verification
REQ-031 SHALL check: ROM pixel alpha=7 for char 0x41 at row 2, col 3, fg=0xF00, bg=0x00F, attr=0 -> o_color=0xF00, 3 cycles after acceptance.
REQ-032 SHALL check: alpha=3, fg=0xFFF, bg=0x000 -> per channel (15*3+3)/7=6, o_color=0x666; the same request with inverse -> (0*3+15*4+3)/7=9, o_color=0x999.
REQ-033 SHALL check: underline with row=7 (CHAR_H=8) on a blank glyph -> o_color=fg; row=6 -> o_color=bg.
REQ-034 SHALL check: BLINK_FRAMES=2, 2 frame pulses, blink attr -> o_color=bg; after 2 more pulses -> glyph restored.
REQ-035 SHALL check: a stream of 10 requests with i_ready toggled randomly -> 10 outputs in order, none lost or duplicated, o_ready=0 exactly when v3=1 and i_ready=0.
REQ-036 SHALL check: i_rst_n=0 for 1 cycle with 3 requests in flight -> no o_valid afterwards, o_color=0x000, and the blink counter is 0.

Source files
------------

// File: rtl/video_pkg.sv
// video_pkg: shared video definitions for the character blender.
//   - attribute bit indices carried with each pixel request
//   - RGB 4:4:4 colour layout (channel width and field positions)
//   - pix_req_t: per-pixel side data carried down the blender pipeline
package video_pkg;

    localparam int ATTR_W         = 3;
    localparam int ATTR_INVERSE   = 0;
    localparam int ATTR_UNDERLINE = 1;
    localparam int ATTR_BLINK     = 2;

    localparam int CH_W  = 4;
    localparam int RGB_W = 3 * CH_W;
    localparam int R_LSB = 2 * CH_W;
    localparam int G_LSB = CH_W;
    localparam int B_LSB = 0;

    // last_row is resolved at capture so later stages need no row width.
    typedef struct packed {
        logic [RGB_W-1:0]  fg;
        logic [RGB_W-1:0]  bg;
        logic [ATTR_W-1:0] attr;
        logic              last_row;
        logic              phase;
    } pix_req_t;

endpackage

// File: rtl/char_glyph_rom.sv
// char_glyph_rom: glyph alpha ROM with registered, enabled read.
//   clk   : clock
//   en    : read enable; output register holds while low
//   addr  : {char[7:0], row, column}
//   alpha : ALPHA_BITS glyph coverage, valid the cycle after en
// Contents come from a closed-form table: chars 0x00 and 0x20 are blank,
// every other cell is (char + row*column) mod 2^ALPHA_BITS. GLYPH_FILE names
// the matching .mem image for flows that preload block RAM; an empty name
// builds an all-blank font. Contents are never touched by reset.
module char_glyph_rom #(
    parameter int    CHAR_W     = 8,
    parameter int    CHAR_H     = 8,
    parameter int    ALPHA_BITS = 3,
    parameter string GLYPH_FILE = "glyphs.mem"
) (
    input  logic                                           clk,
    input  logic                                           en,
    input  logic [8+$clog2(CHAR_H)+$clog2(CHAR_W)-1:0]     addr,
    output logic [ALPHA_BITS-1:0]                          alpha
);

    localparam int RW = $clog2(CHAR_H);
    localparam int CW = $clog2(CHAR_W);
    localparam int AW = 8 + RW + CW;
    localparam bit BLANK_FONT = (GLYPH_FILE == "");

    function automatic logic [ALPHA_BITS-1:0] glyph_alpha(input logic [AW-1:0] a);
        logic [7:0] ch;
        int         row;
        int         col;
        ch  = a[AW-1 -: 8];
        row = int'(a[CW +: RW]);
        col = int'(a[CW-1:0]);
        if (BLANK_FONT || ch == 8'h00 || ch == 8'h20) return '0;
        return ALPHA_BITS'(int'(ch) + row * col);
    endfunction

    always_ff @(posedge clk) begin
        if (en) alpha <= glyph_alpha(addr);
    end

endmodule

// File: rtl/char_blender_pipe.sv
// char_blender_pipe: 3-stage text-mode pixel blender.
//   S1 captures the request, glyph address and current blink phase,
//   S2 reads the glyph ROM, S3 applies attributes, blends fg/bg by alpha and
//   registers o_color. Result appears 3 cycles after acceptance.
// Ports:
//   i_clk, i_rst_n        : clock, synchronous active-low reset
//   i_frame_start         : one pulse per frame, drives the blink counter
//   i_valid/o_ready       : request handshake
//   i_char,i_row,i_column : glyph cell lookup
//   i_fg_color,i_bg_color : RGB 4:4:4 colours
//   i_attr                : {blink, underline, inverse}
//   o_valid/i_ready       : result handshake
//   o_color               : blended RGB 4:4:4, held while o_valid is low
module char_blender_pipe
    import video_pkg::*;
#(
    parameter int    CHAR_W       = 8,
    parameter int    CHAR_H       = 8,
    parameter int    ALPHA_BITS   = 3,
    parameter int    BLINK_FRAMES = 32,
    parameter string GLYPH_FILE   = "glyphs.mem"
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic                        i_frame_start,
    input  logic                        i_valid,
    output logic                        o_ready,
    input  logic [7:0]                  i_char,
    input  logic [$clog2(CHAR_H)-1:0]   i_row,
    input  logic [$clog2(CHAR_W)-1:0]   i_column,
    input  logic [RGB_W-1:0]            i_fg_color,
    input  logic [RGB_W-1:0]            i_bg_color,
    input  logic [ATTR_W-1:0]           i_attr,
    output logic                        o_valid,
    input  logic                        i_ready,
    output logic [RGB_W-1:0]            o_color
);

    localparam int STAGES = 3;
    localparam int RW     = $clog2(CHAR_H);
    localparam int CW     = $clog2(CHAR_W);
    localparam int AW     = 8 + RW + CW;
    localparam int BW     = CH_W + ALPHA_BITS + 1;
    localparam int CNT_W  = $clog2(BLINK_FRAMES);
    localparam logic [ALPHA_BITS-1:0] AMAX = '1;

    logic [STAGES:1]        vld_pipe;
    logic                   adv;
    logic [AW-1:0]          s1_addr;
    pix_req_t               s1_req, s2_req;
    logic [ALPHA_BITS-1:0]  rom_alpha;
    logic [CNT_W-1:0]       blink_cnt;
    logic                   blink_phase;
    logic [ALPHA_BITS-1:0]  eff_alpha;
    logic [RGB_W-1:0]       fg_sel, bg_sel, blend_rgb;

    // Whole pipe moves in lockstep; only a full, unaccepted output stalls it.
    assign adv     = !vld_pipe[STAGES] || i_ready;
    assign o_ready = adv;
    assign o_valid = vld_pipe[STAGES];

    // Blink timing is frame-based and keeps running through stalls.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (i_frame_start) begin
            if (blink_cnt == CNT_W'(BLINK_FRAMES - 1)) begin
                blink_cnt   <= '0;
                blink_phase <= !blink_phase;
            end else begin
                blink_cnt <= blink_cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n)  vld_pipe <= '0;
        else if (adv)  vld_pipe <= {vld_pipe[STAGES-1:1], i_valid};
    end

    // Payload needs no reset; validity lives in vld_pipe.
    always_ff @(posedge i_clk) begin
        if (adv) begin
            s1_addr <= {i_char, i_row, i_column};
            s1_req  <= '{fg:       i_fg_color,
                         bg:       i_bg_color,
                         attr:     i_attr,
                         last_row: (i_row == RW'(CHAR_H - 1)),
                         phase:    blink_phase};
            s2_req  <= s1_req;
        end
    end

    char_glyph_rom #(
        .CHAR_W     (CHAR_W),
        .CHAR_H     (CHAR_H),
        .ALPHA_BITS (ALPHA_BITS),
        .GLYPH_FILE (GLYPH_FILE)
    ) u_rom (
        .clk   (i_clk),
        .en    (adv),
        .addr  (s1_addr),
        .alpha (rom_alpha)
    );

    // Rounded divide by AMAX makes a=0 and a=AMAX exact endpoints.
    function automatic logic [CH_W-1:0] blend_ch(input logic [CH_W-1:0]       f,
                                                 input logic [CH_W-1:0]       b,
                                                 input logic [ALPHA_BITS-1:0] a);
        logic [BW-1:0] num;
        num = BW'(f) * BW'(a) + BW'(b) * BW'(AMAX - a) + BW'(AMAX >> 1);
        return CH_W'(num / BW'(AMAX));
    endfunction

    // Blink-off wins over underline so a blinking cell vanishes entirely.
    always_comb begin
        eff_alpha = rom_alpha;
        fg_sel    = s2_req.fg;
        bg_sel    = s2_req.bg;
        if (s2_req.attr[ATTR_UNDERLINE] && s2_req.last_row) eff_alpha = AMAX;
        if (s2_req.attr[ATTR_BLINK] && s2_req.phase)        eff_alpha = '0;
        if (s2_req.attr[ATTR_INVERSE]) begin
            fg_sel = s2_req.bg;
            bg_sel = s2_req.fg;
        end
        blend_rgb = '0;
        blend_rgb[R_LSB +: CH_W] = blend_ch(fg_sel[R_LSB +: CH_W], bg_sel[R_LSB +: CH_W], eff_alpha);
        blend_rgb[G_LSB +: CH_W] = blend_ch(fg_sel[G_LSB +: CH_W], bg_sel[G_LSB +: CH_W], eff_alpha);
        blend_rgb[B_LSB +: CH_W] = blend_ch(fg_sel[B_LSB +: CH_W], bg_sel[B_LSB +: CH_W], eff_alpha);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n)                o_color <= '0;
        else if (adv && vld_pipe[2]) o_color <= blend_rgb;
    end

endmodule

// File: tb/tb_char_blender_pipe.sv
module tb_char_blender_pipe;

    localparam int BF = 2;

    logic        i_clk, i_rst_n, i_frame_start, i_valid, o_ready, o_valid, i_ready;
    logic [7:0]  i_char;
    logic [2:0]  i_row, i_column, i_attr;
    logic [11:0] i_fg_color, i_bg_color, o_color;

    char_blender_pipe #(
        .CHAR_W(8), .CHAR_H(8), .ALPHA_BITS(3), .BLINK_FRAMES(BF), .GLYPH_FILE("glyphs.mem")
    ) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_frame_start(i_frame_start),
        .i_valid(i_valid), .o_ready(o_ready), .i_char(i_char), .i_row(i_row),
        .i_column(i_column), .i_fg_color(i_fg_color), .i_bg_color(i_bg_color),
        .i_attr(i_attr), .o_valid(o_valid), .i_ready(i_ready), .o_color(o_color)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int checks = 0;
    int errors = 0;
    int out_cnt = 0;

    // model state
    logic [11:0] exp_q[$];
    logic [11:0] last_exp = '0;
    int          blink_cnt_m = 0;
    bit          phase_m = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Glyph table: blank for 0x00/0x20, else (char + row*col) mod 8.
    function automatic int rom_m(input logic [7:0] ch, input int row, input int col);
        if (ch == 8'h00 || ch == 8'h20) return 0;
        return (int'(ch) + row * col) % 8;
    endfunction

    function automatic logic [11:0] model_px(input logic [7:0] ch, input int row, input int col,
                                             input logic [11:0] fg, input logic [11:0] bg,
                                             input logic [2:0] attr, input bit ph);
        int a, f, b;
        logic [11:0] r;
        a = rom_m(ch, row, col);
        if (attr[1] && row == 7) a = 7;
        if (attr[2] && ph) a = 0;
        r = '0;
        for (int c = 0; c < 3; c++) begin
            f = attr[0] ? int'(bg[c*4 +: 4]) : int'(fg[c*4 +: 4]);
            b = attr[0] ? int'(fg[c*4 +: 4]) : int'(bg[c*4 +: 4]);
            r[c*4 +: 4] = 4'((f * a + b * (7 - a) + 3) / 7);
        end
        return r;
    endfunction

    // Compare process: inputs change 2ns after posedge, so everything is
    // stable here and describes what the next posedge will do.
    always @(negedge i_clk) begin
        if (!i_rst_n) begin
            exp_q.delete();
            last_exp    = '0;
            blink_cnt_m = 0;
            phase_m     = 0;
        end else begin
            if (o_valid) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_valid", o_valid, 0);
                end else begin
                    chk("o_color", o_color, exp_q[0]);
                    if (i_ready) begin
                        last_exp = exp_q.pop_front();
                        out_cnt++;
                    end
                end
            end else begin
                chk("o_color_hold", o_color, last_exp);
            end
            chk("o_ready", o_ready, !o_valid || i_ready);
            if (i_valid && (!o_valid || i_ready))
                exp_q.push_back(model_px(i_char, int'(i_row), int'(i_column),
                                         i_fg_color, i_bg_color, i_attr, phase_m));
            if (i_frame_start) begin
                if (blink_cnt_m == BF - 1) begin
                    blink_cnt_m = 0;
                    phase_m     = !phase_m;
                end else begin
                    blink_cnt_m++;
                end
            end
        end
    end

    task automatic cyc();
        @(posedge i_clk);
        #2;
    endtask

    task automatic set_req(input logic [7:0] ch, input int row, input int col,
                           input logic [11:0] fg, input logic [11:0] bg, input logic [2:0] attr);
        i_char = ch; i_row = 3'(row); i_column = 3'(col);
        i_fg_color = fg; i_bg_color = bg; i_attr = attr;
    endtask

    task automatic rand_req();
        logic [7:0] ch;
        case ($urandom_range(0, 3))
            0:       ch = 8'h20;
            1:       ch = 8'h41;
            default: ch = 8'($urandom);
        endcase
        set_req(ch, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                12'($urandom), 12'($urandom), 3'($urandom));
    endtask

    // Single request into an empty pipe; pins exact 3-cycle latency.
    task automatic send1(input string nm, input logic [7:0] ch, input int row, input int col,
                         input logic [11:0] fg, input logic [11:0] bg, input logic [2:0] attr,
                         input logic [11:0] exp);
        set_req(ch, row, col, fg, bg, attr);
        i_valid = 1; i_ready = 1;
        cyc();
        i_valid = 0;
        cyc();
        @(negedge i_clk);
        chk({nm, "_early"}, o_valid, 0);
        cyc();
        @(negedge i_clk);
        chk({nm, "_valid"}, o_valid, 1);
        chk(nm, o_color, exp);
        cyc();
    endtask

    task automatic frame_pulse();
        i_frame_start = 1;
        cyc();
        i_frame_start = 0;
    endtask

    task automatic drain();
        int g;
        g = 0;
        i_valid = 0;
        i_frame_start = 0;
        while (exp_q.size() != 0 && g < 300) begin
            i_ready = 1'($urandom_range(0, 1));
            cyc();
            g++;
        end
        i_ready = 1;
        repeat (4) cyc();
        chk("drain_empty", exp_q.size(), 0);
    endtask

    initial begin
        int base, sent, guard;
        i_rst_n = 0; i_frame_start = 0; i_valid = 0; i_ready = 1;
        set_req(8'h00, 0, 0, 12'h000, 12'h000, 3'b000);
        repeat (2) cyc();
        @(negedge i_clk);
        chk("reset_valid", o_valid, 0);
        chk("reset_color", o_color, 0);
        chk("reset_ready", o_ready, 1);
        cyc();
        i_rst_n = 1;
        cyc();

        send1("glyph_full",    8'h41, 2, 3, 12'hF00, 12'h00F, 3'b000, 12'hF00);
        send1("glyph_a3",      8'h41, 1, 2, 12'hFFF, 12'h000, 3'b000, 12'h666);
        send1("glyph_a3_inv",  8'h41, 1, 2, 12'hFFF, 12'h000, 3'b001, 12'h999);
        send1("uline_row7",    8'h20, 7, 4, 12'hABC, 12'h123, 3'b010, 12'hABC);
        send1("uline_row6",    8'h20, 6, 4, 12'hABC, 12'h123, 3'b010, 12'h123);
        frame_pulse();
        frame_pulse();
        send1("blink_off",     8'h41, 2, 3, 12'hF00, 12'h00F, 3'b100, 12'h00F);
        send1("blink_uline",   8'h20, 7, 0, 12'hF00, 12'h00F, 3'b110, 12'h00F);
        frame_pulse();
        frame_pulse();
        send1("blink_on",      8'h41, 2, 3, 12'hF00, 12'h00F, 3'b100, 12'hF00);

        // 10-request stream under random backpressure
        base = out_cnt; sent = 0; guard = 0;
        while (sent < 10 && guard < 400) begin
            rand_req();
            i_valid = 1;
            i_ready = 1'($urandom_range(0, 1));
            #1;
            if (o_ready) sent++;
            cyc();
            guard++;
        end
        i_valid = 0;
        drain();
        chk("stream_sent", sent, 10);
        chk("stream_out", out_cnt - base, 10);

        // random traffic with frame pulses
        repeat (300) begin
            rand_req();
            i_valid       = ($urandom_range(0, 9) < 7);
            i_ready       = ($urandom_range(0, 9) < 7);
            i_frame_start = ($urandom_range(0, 9) == 0);
            cyc();
        end
        drain();

        // reset with three requests in flight
        if (blink_cnt_m == 0) frame_pulse();
        i_ready = 1;
        for (int k = 0; k < 3; k++) begin
            rand_req();
            i_valid = 1;
            cyc();
        end
        i_valid = 0; i_ready = 0; i_rst_n = 0;
        cyc();
        i_rst_n = 1; i_ready = 1;
        @(negedge i_clk);
        chk("rst_valid", o_valid, 0);
        chk("rst_color", o_color, 0);
        chk("rst_blink_cnt", dut.blink_cnt, 0);
        chk("rst_ready", o_ready, 1);
        repeat (5) begin
            cyc();
            @(negedge i_clk);
            chk("rst_no_valid", o_valid, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not reach its end, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule
